// File: rtl/ip_tx_arbiter.sv
// Two-source IP TX arbiter: picks the ICMP-reply or UDP source, registers its header,
// then passes its payload stream through until tlast. Counts completed frames per source.
module ip_tx_arbiter #(
   parameter bit RR_EN = 1'b1
) (
   input  logic        clk,
   input  logic        rst_n,

   input  logic        s0_ip_hdr_valid,
   output logic        s0_ip_hdr_ready,
   input  logic [5:0]  s0_ip_dscp,
   input  logic [1:0]  s0_ip_ecn,
   input  logic [15:0] s0_ip_length,
   input  logic [7:0]  s0_ip_ttl,
   input  logic [7:0]  s0_ip_protocol,
   input  logic [31:0] s0_ip_source_ip,
   input  logic [31:0] s0_ip_dest_ip,
   input  logic [7:0]  s0_payload_axis_tdata,
   input  logic        s0_payload_axis_tvalid,
   input  logic        s0_payload_axis_tlast,
   input  logic        s0_payload_axis_tuser,
   output logic        s0_payload_axis_tready,

   input  logic        s1_ip_hdr_valid,
   output logic        s1_ip_hdr_ready,
   input  logic [5:0]  s1_ip_dscp,
   input  logic [1:0]  s1_ip_ecn,
   input  logic [15:0] s1_ip_length,
   input  logic [7:0]  s1_ip_ttl,
   input  logic [7:0]  s1_ip_protocol,
   input  logic [31:0] s1_ip_source_ip,
   input  logic [31:0] s1_ip_dest_ip,
   input  logic [7:0]  s1_payload_axis_tdata,
   input  logic        s1_payload_axis_tvalid,
   input  logic        s1_payload_axis_tlast,
   input  logic        s1_payload_axis_tuser,
   output logic        s1_payload_axis_tready,

   output logic        m_ip_hdr_valid,
   input  logic        m_ip_hdr_ready,
   output logic [5:0]  m_ip_dscp,
   output logic [1:0]  m_ip_ecn,
   output logic [15:0] m_ip_length,
   output logic [7:0]  m_ip_ttl,
   output logic [7:0]  m_ip_protocol,
   output logic [31:0] m_ip_source_ip,
   output logic [31:0] m_ip_dest_ip,
   output logic [7:0]  m_payload_axis_tdata,
   output logic        m_payload_axis_tvalid,
   output logic        m_payload_axis_tlast,
   output logic        m_payload_axis_tuser,
   input  logic        m_payload_axis_tready,

   output logic [1:0]  grant,
   output logic [15:0] frame_counter0,
   output logic [15:0] frame_counter1,
   input  logic        clear_counter
);

   localparam int unsigned HDR_W = 6 + 2 + 16 + 8 + 8 + 32 + 32;
   localparam int unsigned CNT_W = 16;

   localparam logic [1:0] ST_IDLE    = 2'd0;
   localparam logic [1:0] ST_HDR     = 2'd1;
   localparam logic [1:0] ST_PAYLOAD = 2'd2;

   logic [1:0]       state_q, state_d;
   logic [1:0]       grant_q, grant_d;
   logic             last_owner_q, last_owner_d;
   logic             hdr_valid_q, hdr_valid_d;
   logic [HDR_W-1:0] hdr_q, hdr_d;
   logic [CNT_W-1:0] cnt0_q, cnt0_d;
   logic [CNT_W-1:0] cnt1_q, cnt1_d;
   logic             clear_prev_q;

   logic             sel1;
   logic             load_hdr;
   logic             frame_done;
   logic             clr_edge;
   logic [HDR_W-1:0] s0_hdr, s1_hdr;

   assign s0_hdr = {s0_ip_dscp, s0_ip_ecn, s0_ip_length, s0_ip_ttl,
                    s0_ip_protocol, s0_ip_source_ip, s0_ip_dest_ip};
   assign s1_hdr = {s1_ip_dscp, s1_ip_ecn, s1_ip_length, s1_ip_ttl,
                    s1_ip_protocol, s1_ip_source_ip, s1_ip_dest_ip};

   // Winner select: lone requester wins; a tie goes to source 0 unless round-robin says otherwise
   always_comb begin
      sel1 = 1'b0;
      if (s1_ip_hdr_valid && !s0_ip_hdr_valid) begin
         sel1 = 1'b1;
      end else if (s1_ip_hdr_valid && s0_ip_hdr_valid && RR_EN && !last_owner_q) begin
         sel1 = 1'b1;
      end
   end

   // Header accept goes only to the owner while the header is offered
   always_comb begin
      s0_ip_hdr_ready = 1'b0;
      s1_ip_hdr_ready = 1'b0;
      if (state_q == ST_HDR) begin
         s0_ip_hdr_ready = grant_q[0] && m_ip_hdr_ready;
         s1_ip_hdr_ready = grant_q[1] && m_ip_hdr_ready;
      end
   end

   // Payload pass-through from the owner; everything idle outside PAYLOAD
   always_comb begin
      m_payload_axis_tdata   = 8'd0;
      m_payload_axis_tvalid  = 1'b0;
      m_payload_axis_tlast   = 1'b0;
      m_payload_axis_tuser   = 1'b0;
      s0_payload_axis_tready = 1'b0;
      s1_payload_axis_tready = 1'b0;
      if (state_q == ST_PAYLOAD) begin
         if (grant_q[1]) begin
            m_payload_axis_tdata   = s1_payload_axis_tdata;
            m_payload_axis_tvalid  = s1_payload_axis_tvalid;
            m_payload_axis_tlast   = s1_payload_axis_tlast;
            m_payload_axis_tuser   = s1_payload_axis_tuser;
            s1_payload_axis_tready = m_payload_axis_tready;
         end else begin
            m_payload_axis_tdata   = s0_payload_axis_tdata;
            m_payload_axis_tvalid  = s0_payload_axis_tvalid;
            m_payload_axis_tlast   = s0_payload_axis_tlast;
            m_payload_axis_tuser   = s0_payload_axis_tuser;
            s0_payload_axis_tready = m_payload_axis_tready;
         end
      end
   end

   assign frame_done = (state_q == ST_PAYLOAD) && m_payload_axis_tvalid &&
                       m_payload_axis_tready && m_payload_axis_tlast;

   // Next-state logic
   always_comb begin
      state_d      = state_q;
      grant_d      = grant_q;
      last_owner_d = last_owner_q;
      hdr_valid_d  = hdr_valid_q;
      load_hdr     = 1'b0;
      case (state_q)
         ST_IDLE: begin
            if (s0_ip_hdr_valid || s1_ip_hdr_valid) begin
               load_hdr    = 1'b1;
               grant_d     = sel1 ? 2'b10 : 2'b01;
               hdr_valid_d = 1'b1;
               state_d     = ST_HDR;
            end
         end
         ST_HDR: begin
            if (m_ip_hdr_ready) begin
               hdr_valid_d = 1'b0;
               state_d     = ST_PAYLOAD;
            end
         end
         ST_PAYLOAD: begin
            if (frame_done) begin
               last_owner_d = grant_q[1];
               grant_d      = 2'b00;
               state_d      = ST_IDLE;
            end
         end
         default: begin
            grant_d     = 2'b00;
            hdr_valid_d = 1'b0;
            state_d     = ST_IDLE;
         end
      endcase
   end

   // Header is captured once at grant and held until the next grant
   always_comb begin
      hdr_d = hdr_q;
      if (load_hdr) begin
         hdr_d = sel1 ? s1_hdr : s0_hdr;
      end
   end

   // Clear edge zeroes first, so a coincident completion leaves the counter at 1
   assign clr_edge = clear_counter && !clear_prev_q;

   always_comb begin
      cnt0_d = clr_edge ? CNT_W'(0) : cnt0_q;
      cnt1_d = clr_edge ? CNT_W'(0) : cnt1_q;
      if (frame_done && grant_q[0]) begin
         cnt0_d = cnt0_d + CNT_W'(1);
      end
      if (frame_done && grant_q[1]) begin
         cnt1_d = cnt1_d + CNT_W'(1);
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= ST_IDLE;
         grant_q      <= 2'b00;
         last_owner_q <= 1'b1;
         hdr_valid_q  <= 1'b0;
         hdr_q        <= '0;
         cnt0_q       <= '0;
         cnt1_q       <= '0;
         clear_prev_q <= 1'b0;
      end else begin
         state_q      <= state_d;
         grant_q      <= grant_d;
         last_owner_q <= last_owner_d;
         hdr_valid_q  <= hdr_valid_d;
         hdr_q        <= hdr_d;
         cnt0_q       <= cnt0_d;
         cnt1_q       <= cnt1_d;
         clear_prev_q <= clear_counter;
      end
   end

   assign {m_ip_dscp, m_ip_ecn, m_ip_length, m_ip_ttl,
           m_ip_protocol, m_ip_source_ip, m_ip_dest_ip} = hdr_q;
   assign m_ip_hdr_valid = hdr_valid_q;
   assign grant          = grant_q;
   assign frame_counter0 = cnt0_q;
   assign frame_counter1 = cnt1_q;

endmodule

// File: tb/tb_ip_tx_arbiter.sv
// Directed bench for ip_tx_arbiter: round-robin instance plus a fixed-priority instance
// sharing the same source/sink stimulus.
module tb_ip_tx_arbiter;

   logic clk, rst_n;
   logic        s0_ip_hdr_valid, s1_ip_hdr_valid;
   logic [5:0]  s0_ip_dscp, s1_ip_dscp;
   logic [1:0]  s0_ip_ecn, s1_ip_ecn;
   logic [15:0] s0_ip_length, s1_ip_length;
   logic [7:0]  s0_ip_ttl, s1_ip_ttl, s0_ip_protocol, s1_ip_protocol;
   logic [31:0] s0_ip_source_ip, s1_ip_source_ip, s0_ip_dest_ip, s1_ip_dest_ip;
   logic [7:0]  s0_payload_axis_tdata, s1_payload_axis_tdata;
   logic        s0_payload_axis_tvalid, s1_payload_axis_tvalid;
   logic        s0_payload_axis_tlast, s1_payload_axis_tlast;
   logic        s0_payload_axis_tuser, s1_payload_axis_tuser;
   logic        m_ip_hdr_ready, m_payload_axis_tready, clear_counter;

   // round-robin DUT outputs
   logic        s0_ip_hdr_ready, s1_ip_hdr_ready, s0_payload_axis_tready, s1_payload_axis_tready;
   logic        m_ip_hdr_valid;
   logic [5:0]  m_ip_dscp;
   logic [1:0]  m_ip_ecn;
   logic [15:0] m_ip_length;
   logic [7:0]  m_ip_ttl, m_ip_protocol;
   logic [31:0] m_ip_source_ip, m_ip_dest_ip;
   logic [7:0]  m_payload_axis_tdata;
   logic        m_payload_axis_tvalid, m_payload_axis_tlast, m_payload_axis_tuser;
   logic [1:0]  grant;
   logic [15:0] frame_counter0, frame_counter1;

   // fixed-priority DUT outputs
   logic        f_s0_hdr_ready, f_s1_hdr_ready, f_s0_tready, f_s1_tready, f_hdr_valid;
   logic [5:0]  f_dscp;
   logic [1:0]  f_ecn;
   logic [15:0] f_length;
   logic [7:0]  f_ttl, f_protocol;
   logic [31:0] f_source_ip, f_dest_ip;
   logic [7:0]  f_tdata;
   logic        f_tvalid, f_tlast, f_tuser;
   logic [1:0]  f_grant;
   logic [15:0] f_fc0, f_fc1;

   int passed = 0;
   int total  = 0;
   int fails  = 0;

   ip_tx_arbiter #(.RR_EN(1'b1)) dut (
      .clk(clk), .rst_n(rst_n),
      .s0_ip_hdr_valid(s0_ip_hdr_valid), .s0_ip_hdr_ready(s0_ip_hdr_ready),
      .s0_ip_dscp(s0_ip_dscp), .s0_ip_ecn(s0_ip_ecn), .s0_ip_length(s0_ip_length),
      .s0_ip_ttl(s0_ip_ttl), .s0_ip_protocol(s0_ip_protocol),
      .s0_ip_source_ip(s0_ip_source_ip), .s0_ip_dest_ip(s0_ip_dest_ip),
      .s0_payload_axis_tdata(s0_payload_axis_tdata), .s0_payload_axis_tvalid(s0_payload_axis_tvalid),
      .s0_payload_axis_tlast(s0_payload_axis_tlast), .s0_payload_axis_tuser(s0_payload_axis_tuser),
      .s0_payload_axis_tready(s0_payload_axis_tready),
      .s1_ip_hdr_valid(s1_ip_hdr_valid), .s1_ip_hdr_ready(s1_ip_hdr_ready),
      .s1_ip_dscp(s1_ip_dscp), .s1_ip_ecn(s1_ip_ecn), .s1_ip_length(s1_ip_length),
      .s1_ip_ttl(s1_ip_ttl), .s1_ip_protocol(s1_ip_protocol),
      .s1_ip_source_ip(s1_ip_source_ip), .s1_ip_dest_ip(s1_ip_dest_ip),
      .s1_payload_axis_tdata(s1_payload_axis_tdata), .s1_payload_axis_tvalid(s1_payload_axis_tvalid),
      .s1_payload_axis_tlast(s1_payload_axis_tlast), .s1_payload_axis_tuser(s1_payload_axis_tuser),
      .s1_payload_axis_tready(s1_payload_axis_tready),
      .m_ip_hdr_valid(m_ip_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
      .m_ip_dscp(m_ip_dscp), .m_ip_ecn(m_ip_ecn), .m_ip_length(m_ip_length),
      .m_ip_ttl(m_ip_ttl), .m_ip_protocol(m_ip_protocol),
      .m_ip_source_ip(m_ip_source_ip), .m_ip_dest_ip(m_ip_dest_ip),
      .m_payload_axis_tdata(m_payload_axis_tdata), .m_payload_axis_tvalid(m_payload_axis_tvalid),
      .m_payload_axis_tlast(m_payload_axis_tlast), .m_payload_axis_tuser(m_payload_axis_tuser),
      .m_payload_axis_tready(m_payload_axis_tready),
      .grant(grant), .frame_counter0(frame_counter0), .frame_counter1(frame_counter1),
      .clear_counter(clear_counter)
   );

   ip_tx_arbiter #(.RR_EN(1'b0)) dut_fp (
      .clk(clk), .rst_n(rst_n),
      .s0_ip_hdr_valid(s0_ip_hdr_valid), .s0_ip_hdr_ready(f_s0_hdr_ready),
      .s0_ip_dscp(s0_ip_dscp), .s0_ip_ecn(s0_ip_ecn), .s0_ip_length(s0_ip_length),
      .s0_ip_ttl(s0_ip_ttl), .s0_ip_protocol(s0_ip_protocol),
      .s0_ip_source_ip(s0_ip_source_ip), .s0_ip_dest_ip(s0_ip_dest_ip),
      .s0_payload_axis_tdata(s0_payload_axis_tdata), .s0_payload_axis_tvalid(s0_payload_axis_tvalid),
      .s0_payload_axis_tlast(s0_payload_axis_tlast), .s0_payload_axis_tuser(s0_payload_axis_tuser),
      .s0_payload_axis_tready(f_s0_tready),
      .s1_ip_hdr_valid(s1_ip_hdr_valid), .s1_ip_hdr_ready(f_s1_hdr_ready),
      .s1_ip_dscp(s1_ip_dscp), .s1_ip_ecn(s1_ip_ecn), .s1_ip_length(s1_ip_length),
      .s1_ip_ttl(s1_ip_ttl), .s1_ip_protocol(s1_ip_protocol),
      .s1_ip_source_ip(s1_ip_source_ip), .s1_ip_dest_ip(s1_ip_dest_ip),
      .s1_payload_axis_tdata(s1_payload_axis_tdata), .s1_payload_axis_tvalid(s1_payload_axis_tvalid),
      .s1_payload_axis_tlast(s1_payload_axis_tlast), .s1_payload_axis_tuser(s1_payload_axis_tuser),
      .s1_payload_axis_tready(f_s1_tready),
      .m_ip_hdr_valid(f_hdr_valid), .m_ip_hdr_ready(m_ip_hdr_ready),
      .m_ip_dscp(f_dscp), .m_ip_ecn(f_ecn), .m_ip_length(f_length),
      .m_ip_ttl(f_ttl), .m_ip_protocol(f_protocol),
      .m_ip_source_ip(f_source_ip), .m_ip_dest_ip(f_dest_ip),
      .m_payload_axis_tdata(f_tdata), .m_payload_axis_tvalid(f_tvalid),
      .m_payload_axis_tlast(f_tlast), .m_payload_axis_tuser(f_tuser),
      .m_payload_axis_tready(m_payload_axis_tready),
      .grant(f_grant), .frame_counter0(f_fc0), .frame_counter1(f_fc1),
      .clear_counter(clear_counter)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp) begin
         passed++;
      end else begin
         fails++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_defaults();
      s0_ip_hdr_valid = 1'b0;  s1_ip_hdr_valid = 1'b0;
      s0_ip_dscp = 6'h2E;      s1_ip_dscp = 6'h0A;
      s0_ip_ecn = 2'd1;        s1_ip_ecn = 2'd2;
      s0_ip_length = 16'h001C; s1_ip_length = 16'h0030;
      s0_ip_ttl = 8'd64;       s1_ip_ttl = 8'd128;
      s0_ip_protocol = 8'd1;   s1_ip_protocol = 8'd17;
      s0_ip_source_ip = 32'h0A000001; s1_ip_source_ip = 32'h0A000001;
      s0_ip_dest_ip = 32'h0A000002;   s1_ip_dest_ip = 32'hC0A80105;
      s0_payload_axis_tdata = 8'd0; s0_payload_axis_tvalid = 1'b0;
      s0_payload_axis_tlast = 1'b0; s0_payload_axis_tuser = 1'b0;
      s1_payload_axis_tdata = 8'd0; s1_payload_axis_tvalid = 1'b0;
      s1_payload_axis_tlast = 1'b0; s1_payload_axis_tuser = 1'b0;
      m_ip_hdr_ready = 1'b1;
      m_payload_axis_tready = 1'b1;
      clear_counter = 1'b0;
   endtask

   task automatic do_reset();
      set_defaults();
      rst_n = 1'b0;
      tick();
      tick();
      chk("rst_grant", 32'(grant), 32'd0);
      chk("rst_hdr_valid", 32'(m_ip_hdr_valid), 32'd0);
      chk("rst_fc0", 32'(frame_counter0), 32'd0);
      chk("rst_fc1", 32'(frame_counter1), 32'd0);
      chk("rst_length", 32'(m_ip_length), 32'd0);
      chk("rst_dest", m_ip_dest_ip, 32'd0);
      chk("rst_tvalid", 32'({m_payload_axis_tvalid, m_payload_axis_tlast, m_payload_axis_tuser}), 32'd0);
      chk("rst_readys", 32'({s0_ip_hdr_ready, s1_ip_hdr_ready,
                             s0_payload_axis_tready, s1_payload_axis_tready}), 32'd0);
      rst_n = 1'b1;
   endtask

   task automatic set_hv(input int w, input logic v);
      if (w == 0) s0_ip_hdr_valid = v;
      else        s1_ip_hdr_valid = v;
   endtask

   task automatic drive_pay(input int w, input logic [7:0] d, input logic v,
                            input logic l, input logic u);
      if (w == 0) begin
         s0_payload_axis_tdata = d; s0_payload_axis_tvalid = v;
         s0_payload_axis_tlast = l; s0_payload_axis_tuser = u;
      end else begin
         s1_payload_axis_tdata = d; s1_payload_axis_tvalid = v;
         s1_payload_axis_tlast = l; s1_payload_axis_tuser = u;
      end
   endtask

   // One complete frame from source w; caller has already raised the requests and the block is idle
   task automatic serve(input int w, input int n, input logic [7:0] base, input logic clr_last);
      logic hr_w, hr_o, tr_w, tr_o;
      #1;
      chk("pre_hdr_valid", 32'(m_ip_hdr_valid), 32'd0);
      tick();
      chk("win_grant", 32'(grant), (w == 0) ? 32'd1 : 32'd2);
      chk("win_hdr_valid", 32'(m_ip_hdr_valid), 32'd1);
      chk("win_length", 32'(m_ip_length), (w == 0) ? 32'h001C : 32'h0030);
      chk("win_dest", m_ip_dest_ip, (w == 0) ? 32'h0A000002 : 32'hC0A80105);
      hr_w = (w == 0) ? s0_ip_hdr_ready : s1_ip_hdr_ready;
      hr_o = (w == 0) ? s1_ip_hdr_ready : s0_ip_hdr_ready;
      chk("hdr_ready_win", 32'(hr_w), 32'd1);
      chk("hdr_ready_other", 32'(hr_o), 32'd0);
      tick();
      set_hv(w, 1'b0);
      chk("hs_valid_drop", 32'(m_ip_hdr_valid), 32'd0);
      for (int i = 0; i < n; i++) begin
         drive_pay(w, base + 8'(i), 1'b1, (i == n - 1), (i == 1));
         if (clr_last && (i == n - 1)) clear_counter = 1'b1;
         #1;
         tr_w = (w == 0) ? s0_payload_axis_tready : s1_payload_axis_tready;
         tr_o = (w == 0) ? s1_payload_axis_tready : s0_payload_axis_tready;
         chk("pay_tdata", 32'(m_payload_axis_tdata), 32'(base + 8'(i)));
         chk("pay_tuser", 32'(m_payload_axis_tuser), (i == 1) ? 32'd1 : 32'd0);
         chk("pay_tlast", 32'(m_payload_axis_tlast), (i == n - 1) ? 32'd1 : 32'd0);
         chk("pay_tready_win", 32'(tr_w), 32'd1);
         chk("pay_tready_other", 32'(tr_o), 32'd0);
         tick();
      end
      drive_pay(w, 8'd0, 1'b0, 1'b0, 1'b0);
      #1;
      chk("end_grant", 32'(grant), 32'd0);
   endtask

   initial begin
      logic [7:0] bp [4];
      int idx, cyc;
      logic acc;

      // single source frame
      do_reset();
      set_hv(0, 1'b1);
      serve(0, 8, 8'hA0, 1'b0);
      chk("single_fc0", 32'(frame_counter0), 32'd1);

      // ties alternate under round-robin, starting with source 0
      do_reset();
      set_hv(0, 1'b1); set_hv(1, 1'b1);
      serve(0, 2, 8'h10, 1'b0);
      set_hv(0, 1'b1);
      serve(1, 2, 8'h20, 1'b0);
      set_hv(1, 1'b1);
      serve(0, 3, 8'h30, 1'b0);
      serve(1, 2, 8'h40, 1'b0);
      chk("rr_fc0", 32'(frame_counter0), 32'd2);
      chk("rr_fc1", 32'(frame_counter1), 32'd2);

      // header backpressure with changing source fields, then toggling payload ready
      set_hv(0, 1'b1);
      m_ip_hdr_ready = 1'b0;
      tick();
      for (int c = 0; c < 5; c++) begin
         s0_ip_length = 16'hFFFF;
         s0_ip_dest_ip = 32'hDEADBEEF;
         #1;
         chk("bp_len_stable", 32'(m_ip_length), 32'h001C);
         chk("bp_dest_stable", m_ip_dest_ip, 32'h0A000002);
         chk("bp_hdr_ready0", 32'(s0_ip_hdr_ready), 32'd0);
         chk("bp_hdr_valid", 32'(m_ip_hdr_valid), 32'd1);
         tick();
      end
      m_ip_hdr_ready = 1'b1;
      #1;
      chk("bp_hdr_ready_hs", 32'(s0_ip_hdr_ready), 32'd1);
      tick();
      set_hv(0, 1'b0);
      s0_ip_length = 16'h001C;
      s0_ip_dest_ip = 32'h0A000002;
      bp = '{8'h11, 8'h22, 8'h33, 8'h44};
      idx = 0;
      cyc = 0;
      while (idx < 4 && cyc < 20) begin
         drive_pay(0, bp[idx], 1'b1, (idx == 3), 1'b0);
         m_payload_axis_tready = (cyc % 2 == 1);
         #1;
         chk("bp_tdata", 32'(m_payload_axis_tdata), 32'(bp[idx]));
         chk("bp_tready", 32'(s0_payload_axis_tready), 32'(m_payload_axis_tready));
         acc = m_payload_axis_tready;
         tick();
         if (acc) idx++;
         cyc++;
      end
      chk("bp_all_bytes", 32'(idx), 32'd4);
      drive_pay(0, 8'd0, 1'b0, 1'b0, 1'b0);
      m_payload_axis_tready = 1'b1;
      #1;
      chk("bp_grant_idle", 32'(grant), 32'd0);
      chk("bp_fc0", 32'(frame_counter0), 32'd3);

      // bring frame_counter1 to 7, then clear edge coinciding with its tlast
      for (int k = 0; k < 5; k++) begin
         set_hv(1, 1'b1);
         serve(1, 1, 8'h50, 1'b0);
      end
      chk("pre_clr_fc1", 32'(frame_counter1), 32'd7);
      set_hv(1, 1'b1);
      serve(1, 2, 8'h60, 1'b1);
      chk("clr_fc1", 32'(frame_counter1), 32'd1);
      chk("clr_fc0", 32'(frame_counter0), 32'd0);
      clear_counter = 1'b0;

      // reset on the third payload byte of source 1
      set_hv(1, 1'b1);
      tick();
      tick();
      set_hv(1, 1'b0);
      for (int i = 0; i < 2; i++) begin
         drive_pay(1, 8'h70 + 8'(i), 1'b1, 1'b0, 1'b0);
         tick();
      end
      drive_pay(1, 8'h72, 1'b1, 1'b0, 1'b0);
      rst_n = 1'b0;
      tick();
      rst_n = 1'b1;
      #1;
      chk("mid_rst_grant", 32'(grant), 32'd0);
      chk("mid_rst_tvalid", 32'(m_payload_axis_tvalid), 32'd0);
      chk("mid_rst_tready1", 32'(s1_payload_axis_tready), 32'd0);
      chk("mid_rst_fc0", 32'(frame_counter0), 32'd0);
      chk("mid_rst_fc1", 32'(frame_counter1), 32'd0);
      drive_pay(1, 8'd0, 1'b0, 1'b0, 1'b0);
      set_hv(0, 1'b1);
      serve(0, 3, 8'h80, 1'b0);
      chk("post_rst_fc0", 32'(frame_counter0), 32'd1);
      chk("post_rst_fc1", 32'(frame_counter1), 32'd0);

      // fixed priority: both sources request continuously for three frames
      do_reset();
      set_hv(0, 1'b1); set_hv(1, 1'b1);
      drive_pay(0, 8'h90, 1'b1, 1'b1, 1'b0);
      drive_pay(1, 8'h91, 1'b1, 1'b1, 1'b0);
      for (int c = 0; c < 9; c++) begin
         #1;
         chk("fp_no_s1_grant", 32'(f_grant[1]), 32'd0);
         chk("fp_s1_tready", 32'(f_s1_tready), 32'd0);
         tick();
      end
      chk("fp_fc0", 32'(f_fc0), 32'd3);
      chk("fp_fc1", 32'(f_fc1), 32'd0);

      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule

// File: doc/ip_tx_arbiter.md
IP_TX_ARBITER -- requirements
Module: ip_tx_arbiter

Interface
REQ-001 Parameter RR_EN, default 1: 1 selects round-robin arbitration; 0 selects fixed priority, with source 0 always winning.
REQ-002 Port clk, input, 1 bit: the single clock; all logic is rising-edge.
REQ-003 Port rst_n, input, 1 bit: synchronous, active-low reset.
REQ-004 Port sN_ip_hdr_valid (N=0,1), input, 1 bit: header request from source N (0 = ICMP reply, 1 = UDP TX).
REQ-005 Port sN_ip_hdr_ready, output, 1 bit: header accept to source N.
REQ-006 Ports sN_ip_dscp/ecn/length/ttl/protocol/source_ip/dest_ip, input, 6/2/16/8/8/32/32 bits: header fields of source N.
REQ-007 Ports sN_payload_axis_tdata/tvalid/tlast/tuser, input, 8/1/1/1 bits: payload byte stream of source N.
REQ-008 Port sN_payload_axis_tready, output, 1 bit: payload accept to source N.
REQ-009 Ports m_ip_hdr_valid (output, 1), m_ip_hdr_ready (input, 1), and m_ip_dscp/ecn/length/ttl/protocol/source_ip/dest_ip (output, same widths as REQ-006): arbitrated header to the IP TX path.
REQ-010 Ports m_payload_axis_tdata/tvalid/tlast/tuser (output, 8/1/1/1) and m_payload_axis_tready (input, 1): arbitrated payload stream.
REQ-011 Port grant, output, 2 bits: one-hot current owner; 00 = none.
REQ-012 Ports frame_counter0 and frame_counter1, output, 16 bits each: frames completed per source.
REQ-013 Port clear_counter, input, 1 bit: clears both frame counters on its rising edge.

Function
REQ-014 The state machine shall have exactly three states: IDLE, HDR and PAYLOAD.
REQ-015 In IDLE with at least one sN_ip_hdr_valid high, the winner's header fields shall be registered onto the m_ip_* outputs, grant shall be set, m_ip_hdr_valid shall be set, and the state shall go to HDR; this is 1 cycle of latency.
REQ-016 Arbitration when RR_EN=1: a single requester wins; on a tie, the source other than last_owner wins.
REQ-017 last_owner shall be reset to 1, so that source 0 wins the first tie.
REQ-018 Arbitration when RR_EN=0: source 0 shall win every tie.
REQ-019 In HDR, sN_ip_hdr_ready shall equal m_ip_hdr_ready for the granted source, combinationally, and shall be 0 for the other source.
REQ-020 On the m_ip_hdr_valid&&m_ip_hdr_ready handshake, m_ip_hdr_valid shall clear in the next cycle and the state shall go to PAYLOAD.
REQ-021 In PAYLOAD, the block shall pass through combinationally: m_payload_axis_tdata/tvalid/tlast/tuser from the granted source, and that source's tready from m_payload_axis_tready.
REQ-022 In PAYLOAD, the non-granted source's tready shall be 0.
REQ-023 In IDLE and HDR, m_payload_axis_tvalid shall be 0 and both sN_payload_axis_tready shall be 0.
REQ-024 On an output beat with tvalid&&tready&&tlast, the block shall: set last_owner to the granted source, increment that source's frame counter, clear grant and return to IDLE in the next cycle.
REQ-025 Back-to-back frames: the next arbitration decision shall be made in the IDLE cycle following tlast, giving a minimum gap of 2 cycles between a tlast beat and the next m_ip_hdr_valid.
REQ-026 A request that arrives while another source owns the path shall be held pending, and shall be arbitrated in the next IDLE.
REQ-027 Header outputs shall be registered copies and shall stay stable from HDR entry until the handshake, even if the source's fields change.
REQ-028 Counters shall wrap from 0xFFFF to 0x0000.
REQ-029 clear_counter shall be edge-detected with a registered previous value; on the detected edge, both counters shall go to 0.
REQ-030 If a clear edge and a frame-completion increment for the same counter coincide, that counter shall become 1.
REQ-031 A tuser=1 beat shall be forwarded unchanged; the frame still counts on tlast.

Reset
REQ-032 With rst_n=0 at a clock edge, the block shall enter IDLE and drive: grant=00, last_owner=1, m_ip_hdr_valid=0, all sN_*ready=0, and frame counters=0.
REQ-033 With rst_n=0, all m_ip_* header fields shall be 0 and m_payload_axis_tvalid/tlast/tuser shall be 0.
REQ-034 Reset mid-frame shall abandon the frame without a tlast; neither frame counter shall increment.

Verification
REQ-035 Single source: s0 header (length=0x001C, dest_ip=0x0A000002) plus 8 payload bytes -> m_ip_hdr_valid 1 cycle after s0_ip_hdr_valid; 8 bytes out unchanged; frame_counter0=1; grant returns to 00.
REQ-036 Simultaneous requests after reset, RR_EN=1 -> s0 served first, then s1; repeating the tie -> s0 then s1 again; counters 2/2.
REQ-037 RR_EN=0, both sources requesting continuously for 3 frames -> all 3 grants go to s0; s1_payload_axis_tready stays 0 throughout.
REQ-038 Backpressure: m_ip_hdr_ready=0 for 5 cycles, then 1; m_payload_axis_tready toggling every cycle -> header fields stable while waiting; sN_ip_hdr_ready high only in the handshake cycle; payload passed byte-exact with no duplicated or dropped bytes.
REQ-039 Rising edge of clear_counter coinciding with an s1 tlast beat, frame_counter1=7 beforehand -> frame_counter1=1; frame_counter0 cleared to 0.
REQ-040 rst_n=0 asserted on the 3rd payload byte of s1 -> next cycle in IDLE with grant=00, m_payload_axis_tvalid=0 and counters 0; a fresh s0 frame then completes normally.
